multibyte_add_seq: RTL

//  Byte-serial wide adder sequencer. It sits directly upstream of an internal adder_8bit instance.
//  It accepts two NBYTES-wide operands over a valid/ready handshake and feeds them to the 8-bit

---
 rtl/multibyte_add_seq_if.sv | 46 ++++
 rtl/multibyte_add_seq.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/multibyte_add_seq_if.sv
// ---------------------------------------------------------------------------
// multibyte_add_seq_if
// Handshake/data bundle for the byte-serial wide adder sequencer.
//   in_valid/in_ready   : operand handshake (a, b, cin)
//   out_valid/out_ready : result handshake (sum, cout[, ovf])
//   busy                : sequencer is in RUN or DONE
// Modports: master drives operands and out_ready; slave is the sequencer.
// Optional macro OVF_FLAG_EN adds the ovf result bit.
// ---------------------------------------------------------------------------
interface multibyte_add_seq_if #(
    parameter int unsigned NBYTES = 4
);
    localparam int unsigned W = 8 * NBYTES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef OVF_FLAG_EN
    logic         ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`endif
endinterface

// File: rtl/multibyte_add_seq.sv
// ---------------------------------------------------------------------------
// multibyte_add_seq
// Byte-serial wide adder: accepts two NBYTES-wide operands, adds them one
// byte per cycle (LSB first) through an 8-bit adder with a registered carry,
// then presents sum/cout until accepted downstream.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : multibyte_add_seq_if.slave (in_valid/in_ready/a/b/cin,
//          out_valid/out_ready/sum/cout, busy)
// Optional macro OVF_FLAG_EN adds bus.ovf, the two's-complement overflow of
// the W-bit add, valid alongside out_valid.
// ---------------------------------------------------------------------------
module adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'b0, cin};
endmodule

module multibyte_add_seq #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    multibyte_add_seq_if.slave  bus
);
    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic [IW-1:0] idx_q, idx_d;

    logic [7:0]    add_a, add_b, add_s;
    logic          add_co;

    // Byte select for the current index.
    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (idx_q == IW'(i)) begin
                add_a = a_q[i*8 +: 8];
                add_b = b_q[i*8 +: 8];
            end
        end
    end

    adder_8bit u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .sum  (add_s),
        .cout (add_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d = add_co;
                for (int unsigned i = 0; i < NBYTES; i++) begin
                    if (idx_q == IW'(i)) begin
                        sum_d[i*8 +: 8] = add_s;
                    end
                end
                // idx parks at 0 after the last byte so it never exceeds NBYTES-1.
                if (idx_q == IW'(NBYTES - 1)) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    // Outputs are pure functions of registered state; in_ready never sees out_ready.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.sum       = sum_q;
    assign bus.cout      = carry_q;

`ifdef OVF_FLAG_EN
    assign bus.ovf = (a_q[W-1] == b_q[W-1]) && (sum_q[W-1] != a_q[W-1]);
`endif

endmodule
